// File: rtl/scan_seq_pkg.sv
// Shared definitions for the scan test sequencer.
//   seq_state_e : sequencer FSM states
//   cnt_width() : width needed to count 0..len inclusive
package scan_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SHIFT_IN,
      CAPTURE,
      SHIFT_OUT,
      DONE
   } seq_state_e;

   // Counters must hold CHAIN_LEN itself (the "no failure" marker).
   function automatic int cnt_width(input int len);
      return (len < 1) ? 1 : $clog2(len + 1);
   endfunction

endpackage

// File: rtl/scan_chain_checker.sv
// Per-chain unload checker.
// Ports:
//   refclk, reset : clock and synchronous active-high reset
//   clear         : restart the counters for a new pattern
//   sample        : compare so against exp_bit on this edge
//   idx           : unload bit index of the current sample
//   so, exp_bit   : observed and expected scan-out bit
//   fail_cnt      : number of mismatching bits so far
//   first_fail    : index of first mismatch, CHAIN_LEN if none
//   clean         : counter will still be zero after this edge
module scan_chain_checker #(
   parameter int CHAIN_LEN = 10,
   parameter int CNT_W     = 4
) (
   input  logic             refclk,
   input  logic             reset,
   input  logic             clear,
   input  logic             sample,
   input  logic [CNT_W-1:0] idx,
   input  logic             so,
   input  logic             exp_bit,
   output logic [CNT_W-1:0] fail_cnt,
   output logic [CNT_W-1:0] first_fail,
   output logic             clean
);

   localparam logic [CNT_W-1:0] LEN_C = CNT_W'(CHAIN_LEN);

   logic [CNT_W-1:0] fail_cnt_q;
   logic [CNT_W-1:0] first_fail_q;
   logic             mismatch;

   // 4-state compare: an X or Z on so is treated as a failing bit.
   assign mismatch = sample && (so !== exp_bit);

   always_ff @(posedge refclk) begin
      if (reset || clear) begin
         fail_cnt_q   <= '0;
         first_fail_q <= LEN_C;
      end else if (mismatch) begin
         // Saturate rather than wrap; at most CHAIN_LEN samples occur.
         if (fail_cnt_q != LEN_C) begin
            fail_cnt_q <= fail_cnt_q + 1'b1;
         end
         if (first_fail_q == LEN_C) begin
            first_fail_q <= idx;
         end
      end
   end

   assign fail_cnt   = fail_cnt_q;
   assign first_fail = first_fail_q;
   // Lets the top compute pass on the same edge as the last compare.
   assign clean      = (fail_cnt_q == '0) && !mismatch;

endmodule

// File: rtl/scan_test_sequencer.sv
// Runs one scan pattern through a two-chain scan design: shift in,
// optional capture window, shift out with compare, report results.
// Ports:
//   refclk, reset        : clock and synchronous active-high reset
//   start, abort         : begin / terminate a pattern
//   capture_en, fill     : capture window enable, si value while unloading
//   pat1/pat2, exp1/exp2 : load patterns and expected unload data (bit 0 first)
//   so1, so2             : chain outputs from the design under test
//   se, test_mode, si1/2 : scan controls to the design under test
//   busy, done, pass     : status; done is a one-cycle pulse
//   fail_cnt*, first_fail* : per-chain mismatch results
module scan_test_sequencer
   import scan_seq_pkg::*;
#(
   parameter int CHAIN_LEN   = 10,
   parameter int CAPTURE_CYC = 1,
   parameter int CNT_W       = cnt_width(CHAIN_LEN)
) (
   input  logic                 refclk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 capture_en,
   input  logic                 fill,
   input  logic [CHAIN_LEN-1:0] pat1,
   input  logic [CHAIN_LEN-1:0] pat2,
   input  logic [CHAIN_LEN-1:0] exp1,
   input  logic [CHAIN_LEN-1:0] exp2,
   input  logic                 so1,
   input  logic                 so2,
   output logic                 se,
   output logic                 test_mode,
   output logic                 si1,
   output logic                 si2,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [CNT_W-1:0]     fail_cnt1,
   output logic [CNT_W-1:0]     fail_cnt2,
   output logic [CNT_W-1:0]     first_fail1,
   output logic [CNT_W-1:0]     first_fail2
);

   localparam int               CAP_W  = $clog2(CAPTURE_CYC + 1);
   localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN - 1);
   localparam logic [CAP_W-1:0] CAP_LAST_C = CAP_W'(CAPTURE_CYC - 1);

   seq_state_e           state_q;
   logic [CNT_W-1:0]     bit_q;
   logic [CAP_W-1:0]     cap_q;
   logic [CHAIN_LEN-1:0] pat1_q, pat2_q, exp1_q, exp2_q;
   logic                 cap_en_q, fill_q;
   logic                 se_q, test_mode_q, si1_q, si2_q;
   logic                 busy_q, done_q, pass_q;

   logic                 accept;
   logic                 sample;
   logic [1:0]           so_v, exp_bit_v, clean_v;
   logic [CNT_W-1:0]     fail_cnt_v   [2];
   logic [CNT_W-1:0]     first_fail_v [2];

   assign accept    = (state_q == IDLE) && start && !abort;
   // The abort edge does not count as an unload sample.
   assign sample    = (state_q == SHIFT_OUT) && !abort;
   assign so_v      = {so2, so1};
   // Expected data is shifted right each unload cycle, so bit 0 is current.
   assign exp_bit_v = {exp2_q[0], exp1_q[0]};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_chk
         scan_chain_checker #(
            .CHAIN_LEN (CHAIN_LEN),
            .CNT_W     (CNT_W)
         ) u_chk (
            .refclk     (refclk),
            .reset      (reset),
            .clear      (accept),
            .sample     (sample),
            .idx        (bit_q),
            .so         (so_v[gi]),
            .exp_bit    (exp_bit_v[gi]),
            .fail_cnt   (fail_cnt_v[gi]),
            .first_fail (first_fail_v[gi]),
            .clean      (clean_v[gi])
         );
      end
   endgenerate

   always_ff @(posedge refclk) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_q       <= '0;
         cap_q       <= '0;
         pat1_q      <= '0;
         pat2_q      <= '0;
         exp1_q      <= '0;
         exp2_q      <= '0;
         cap_en_q    <= 1'b0;
         fill_q      <= 1'b0;
         se_q        <= 1'b0;
         test_mode_q <= 1'b0;
         si1_q       <= 1'b0;
         si2_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else if (abort && (state_q != IDLE)) begin
         state_q     <= IDLE;
         se_q        <= 1'b0;
         test_mode_q <= 1'b0;
         si1_q       <= 1'b0;
         si2_q       <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (accept) begin
                  // Bit 0 goes out immediately; the rest sits in the latch.
                  pat1_q      <= pat1 >> 1;
                  pat2_q      <= pat2 >> 1;
                  si1_q       <= pat1[0];
                  si2_q       <= pat2[0];
                  exp1_q      <= exp1;
                  exp2_q      <= exp2;
                  cap_en_q    <= capture_en;
                  fill_q      <= fill;
                  bit_q       <= '0;
                  busy_q      <= 1'b1;
                  test_mode_q <= 1'b1;
                  se_q        <= 1'b1;
                  pass_q      <= 1'b0;
                  state_q     <= SHIFT_IN;
               end
            end
            SHIFT_IN: begin
               if (bit_q == LAST_C) begin
                  bit_q <= '0;
                  si1_q <= fill_q;
                  si2_q <= fill_q;
                  if (cap_en_q) begin
                     se_q    <= 1'b0;
                     cap_q   <= '0;
                     state_q <= CAPTURE;
                  end else begin
                     state_q <= SHIFT_OUT;
                  end
               end else begin
                  bit_q  <= bit_q + 1'b1;
                  si1_q  <= pat1_q[0];
                  si2_q  <= pat2_q[0];
                  pat1_q <= pat1_q >> 1;
                  pat2_q <= pat2_q >> 1;
               end
            end
            CAPTURE: begin
               if (cap_q == CAP_LAST_C) begin
                  se_q    <= 1'b1;
                  state_q <= SHIFT_OUT;
               end else begin
                  cap_q <= cap_q + 1'b1;
               end
            end
            SHIFT_OUT: begin
               exp1_q <= exp1_q >> 1;
               exp2_q <= exp2_q >> 1;
               if (bit_q == LAST_C) begin
                  // Scanning is finished; drop se while done is reported.
                  se_q    <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= &clean_v;
                  state_q <= DONE;
               end else begin
                  bit_q <= bit_q + 1'b1;
               end
            end
            DONE: begin
               done_q      <= 1'b0;
               busy_q      <= 1'b0;
               test_mode_q <= 1'b0;
               si1_q       <= 1'b0;
               si2_q       <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign se          = se_q;
   assign test_mode   = test_mode_q;
   assign si1         = si1_q;
   assign si2         = si2_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign pass        = pass_q;
   assign fail_cnt1   = fail_cnt_v[0];
   assign fail_cnt2   = fail_cnt_v[1];
   assign first_fail1 = first_fail_v[0];
   assign first_fail2 = first_fail_v[1];

endmodule

// File: tb/tb_scan_test_sequencer.sv
module tb_scan_test_sequencer;

   localparam int N  = 10;
   localparam int CC = 1;
   localparam int W  = 4;

   logic         refclk = 1'b0;
   logic         reset, start, abort, capture_en, fill;
   logic [N-1:0] pat1, pat2, exp1, exp2;
   logic         so1, so2;
   logic         se, test_mode, si1, si2, busy, done, pass;
   logic [W-1:0] fail_cnt1, fail_cnt2, first_fail1, first_fail2;

   int tests  = 0;
   int failed = 0;

   always #5 refclk = ~refclk;

   scan_test_sequencer #(.CHAIN_LEN(N), .CAPTURE_CYC(CC)) dut (
      .refclk(refclk), .reset(reset), .start(start), .abort(abort),
      .capture_en(capture_en), .fill(fill),
      .pat1(pat1), .pat2(pat2), .exp1(exp1), .exp2(exp2),
      .so1(so1), .so2(so2), .se(se), .test_mode(test_mode),
      .si1(si1), .si2(si2), .busy(busy), .done(done), .pass(pass),
      .fail_cnt1(fail_cnt1), .fail_cnt2(fail_cnt2),
      .first_fail1(first_fail1), .first_fail2(first_fail2)
   );

   // Model of the scan-inserted design: two N-flop chains, so = last flop.
   // The functional (se=0) capture inverts every flop.
   logic [N-1:0] ch1 = '0, ch2 = '0;
   logic         stuck1 = 1'b0;
   always @(posedge refclk) begin
      if (se) begin
         ch1 <= {ch1[N-2:0], si1};
         ch2 <= {ch2[N-2:0], si2};
      end else if (test_mode) begin
         ch1 <= ~ch1;
         ch2 <= ~ch2;
      end
   end
   assign so1 = stuck1 ? 1'b0 : ch1[N-1];
   assign so2 = ch2[N-1];

   typedef struct {
      logic [N-1:0] pat1, pat2, exp1, exp2;
      logic cap, stuck, fil, exp_pass, stream;
      int   cnt1, cnt2, ff1, ff2;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Runs one pattern; glitch=1 pulses a disturbing start in SHIFT_IN cycle 3.
   task automatic run_vec(input vec_t v, input string tag, input bit glitch);
      int i, done_at, se_hi, se_lo, so_bad, si_bad, c;
      c = v.cap ? CC : 0;
      @(negedge refclk);
      pat1 = v.pat1; pat2 = v.pat2; exp1 = v.exp1; exp2 = v.exp2;
      capture_en = v.cap; fill = v.fil; stuck1 = v.stuck; start = 1'b1;
      @(negedge refclk);
      start = 1'b0;
      i = 0; done_at = -1; se_hi = 0; se_lo = 0; so_bad = 0; si_bad = 0;
      while (i < 100) begin
         if (done) begin
            done_at = i;
            break;
         end
         if (se) se_hi++; else se_lo++;
         if (i >= N + c) begin
            if (so1 !== v.exp1[i-N-c] || so2 !== v.exp2[i-N-c]) so_bad++;
            if (si1 !== v.fil || si2 !== v.fil) si_bad++;
         end
         if (glitch && i == 3) begin
            start = 1'b1; pat1 = '0; exp1 = '1; pat2 = '1; exp2 = '0; capture_en = ~v.cap;
         end
         if (glitch && i == 4) start = 1'b0;
         @(negedge refclk);
         i++;
      end
      chk({tag, ".done_latency"}, done_at, 2 * N + c);
      chk({tag, ".se_high_cycles"}, se_hi, 2 * N);
      chk({tag, ".se_low_cycles"}, se_lo, c);
      chk({tag, ".si_fill"}, si_bad, 0);
      if (v.stream) chk({tag, ".so_stream"}, so_bad, 0);
      chk({tag, ".pass"}, pass, v.exp_pass);
      chk({tag, ".fail_cnt1"}, fail_cnt1, v.cnt1);
      chk({tag, ".fail_cnt2"}, fail_cnt2, v.cnt2);
      chk({tag, ".first_fail1"}, first_fail1, v.ff1);
      chk({tag, ".first_fail2"}, first_fail2, v.ff2);
      @(negedge refclk);
      chk({tag, ".idle_busy"}, {busy, se, test_mode, done}, 4'b0000);
      chk({tag, ".pass_hold"}, pass, v.exp_pass);
      $display("[TB] %s pat1=%h pat2=%h cap=%0d pass=%0d cnt=%0d/%0d ff=%0d/%0d done_at=%0d",
               tag, v.pat1, v.pat2, v.cap, pass, fail_cnt1, fail_cnt2,
               first_fail1, first_fail2, done_at);
      stuck1 = 1'b0;
   endtask

   initial begin
      int dcount;
      reset = 1'b1; start = 1'b0; abort = 1'b0; capture_en = 1'b0; fill = 1'b0;
      pat1 = '0; pat2 = '0; exp1 = '0; exp2 = '0;

      //         pat1    pat2    exp1    exp2    cap st fil pass strm c1 c2 ff1 ff2
      vecs[0] = '{10'h000, 10'h000, 10'h000, 10'h000, 0, 0, 0, 1, 1,  0, 0, 10, 10};
      vecs[1] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF, 0, 0, 1, 1, 1,  0, 0, 10, 10};
      vecs[2] = '{10'h2AA, 10'h155, 10'h2AA, 10'h155, 0, 0, 0, 1, 1,  0, 0, 10, 10};
      vecs[3] = '{10'h3FF, 10'h2AA, 10'h3FF, 10'h2AA, 0, 1, 0, 0, 0, 10, 0,  0, 10};
      // Capture inverts the chain, so expected unload is ~pat.
      vecs[4] = '{10'h015, 10'h0AA, 10'h3EA, 10'h355, 1, 0, 1, 1, 1,  0, 0, 10, 10};
      vecs[5] = '{10'h3FF, 10'h000, 10'h3F7, 10'h201, 0, 0, 0, 0, 0,  1, 2,  3,  0};

      repeat (3) @(negedge refclk);
      chk("reset.outputs", {se, test_mode, si1, si2, busy, done, pass}, 7'b0);
      chk("reset.counters", {fail_cnt1, fail_cnt2}, 8'h00);
      chk("reset.first_fail", {first_fail1, first_fail2}, {4'd10, 4'd10});
      reset = 1'b0;

      for (int k = 0; k < 6; k++) run_vec(vecs[k], $sformatf("vec%0d", k), 1'b0);

      // Start during SHIFT_IN must not disturb the running pattern.
      run_vec(vecs[1], "start_busy", 1'b1);

      // Abort and start together in IDLE: abort wins.
      @(negedge refclk);
      start = 1'b1; abort = 1'b1;
      @(negedge refclk);
      start = 1'b0; abort = 1'b0;
      chk("abort_start.busy", {busy, se, test_mode}, 3'b000);
      $display("[TB] abort+start in IDLE busy=%0d", busy);

      // Abort in SHIFT_OUT cycle 4 of a failing pattern.
      pat1 = '0; exp1 = '1; pat2 = '0; exp2 = '0; capture_en = 1'b0; fill = 1'b0;
      start = 1'b1;
      @(negedge refclk);
      start = 1'b0;
      repeat (N + 4) @(negedge refclk);
      chk("abort.in_shift_out", {busy, se}, 2'b11);
      abort = 1'b1;
      @(negedge refclk);
      abort = 1'b0;
      chk("abort.idle", {busy, se, test_mode, si1, si2, pass}, 6'b0);
      chk("abort.first_fail1", first_fail1, 0);
      dcount = 0;
      for (int k = 0; k < 30; k++) begin
         if (done) dcount++;
         @(negedge refclk);
      end
      chk("abort.no_done", dcount, 0);
      $display("[TB] abort at SHIFT_OUT cycle 4 busy=%0d ff1=%0d", busy, first_fail1);

      // Reset in the capture window, then a clean rerun.
      pat1 = 10'h015; pat2 = 10'h0AA; capture_en = 1'b1; start = 1'b1;
      @(negedge refclk);
      start = 1'b0;
      repeat (N) @(negedge refclk);
      chk("reset_cap.in_capture", {busy, se, test_mode}, 3'b101);
      reset = 1'b1;
      @(negedge refclk);
      reset = 1'b0;
      chk("reset_cap.outputs", {se, test_mode, si1, si2, busy, done, pass}, 7'b0);
      chk("reset_cap.first_fail", {first_fail1, first_fail2, fail_cnt1, fail_cnt2},
          {4'd10, 4'd10, 4'd0, 4'd0});
      $display("[TB] reset mid-capture busy=%0d se=%0d", busy, se);
      run_vec(vecs[4], "after_reset", 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
